// File: rtl/sync_down_counter_pkg.sv
// Shared types and constants for the loadable down counter/timer.
// Used by sync_down_counter and its tff_cell bit slices.
package sync_down_counter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int DEFAULT_WIDTH = 4;

endpackage : sync_down_counter_pkg

// File: rtl/sync_down_counter_tff_cell.sv
// Toggle flip-flop bit slice with async active-high reset to 0 and a
// synchronous parallel load that takes priority over the toggle input.
module tff_cell (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic d,
    input  logic t,
    output logic q
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = d;
        end else if (t) begin
            q_d = ~q_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule : tff_cell

// File: rtl/sync_down_counter.sv
// Loadable down counter/timer built from toggle cells, with a one-cycle
// terminal-count pulse. Define SYNC_DOWN_COUNTER_AUTORELOAD_EN for periodic
// auto-reload at expiry; otherwise the counter stops at 0 and returns to IDLE.
module sync_down_counter
    import sync_down_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] cnt,
    output logic             zero,
    output logic             tc,
    output logic             busy
);

    state_e           state_q;
    state_e           state_d;
    logic             tc_q;
    logic             tc_d;
    logic             expiry;
    logic             dec;
    logic             cell_load;
    logic [WIDTH-1:0] cell_val;
    logic [WIDTH-1:0] expiry_val;
    logic [WIDTH-1:0] tog;
    logic [WIDTH-1:0] cnt_w;

`ifdef SYNC_DOWN_COUNTER_AUTORELOAD_EN
    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] reload_d;

    always_comb begin
        reload_d = reload_q;
        if (load) begin
            reload_d = load_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reload_q <= '0;
        end else begin
            reload_q <= reload_d;
        end
    end

    assign expiry_val = reload_q;
`else
    assign expiry_val = '0;
`endif

    // Expiry is caught at cnt==1 so the count never underflows past zero.
    assign expiry = (state_q == RUN) && en && (cnt_w == WIDTH'(1));
    assign dec    = (state_q == RUN) && en && !expiry;

    // Bit i toggles on a decrement only when every lower bit is already 0.
    always_comb begin
        logic low_zero;
        tog      = '0;
        low_zero = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            tog[i]   = dec & low_zero;
            low_zero = low_zero & ~cnt_w[i];
        end
    end

    assign cell_load = load | expiry;
    assign cell_val  = load ? load_val : expiry_val;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        tff_cell u_cell (
            .clk  (clk),
            .rst  (rst),
            .load (cell_load),
            .d    (cell_val[g]),
            .t    (tog[g]),
            .q    (cnt_w[g])
        );
    end

    always_comb begin
        state_d = state_q;
        tc_d    = 1'b0;
        if (load) begin
            state_d = (load_val != '0) ? RUN : IDLE;
        end else if (expiry) begin
            tc_d = 1'b1;
`ifdef SYNC_DOWN_COUNTER_AUTORELOAD_EN
            state_d = RUN;
`else
            state_d = IDLE;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tc_q    <= tc_d;
        end
    end

    assign cnt  = cnt_w;
    assign zero = (cnt_w == '0);
    assign tc   = tc_q;
    assign busy = (state_q == RUN);

endmodule : sync_down_counter

// File: tb/tb_sync_down_counter.sv
// Bench for sync_down_counter (WIDTH=4): behavioural model checked every
// cycle plus directed vectors with literal expectations.
module tb_sync_down_counter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         en = 1'b0;
    logic [W-1:0] cnt;
    logic         zero;
    logic         tc;
    logic         busy;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Model state
    int m_cnt;
    int m_rel;
    bit m_run;
    bit m_tc;

    sync_down_counter #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .cnt      (cnt),
        .zero     (zero),
        .tc       (tc),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt = 0;
            m_rel = 0;
            m_run = 1'b0;
            m_tc  = 1'b0;
        end else if (load) begin
            m_cnt = int'(load_val);
            m_rel = int'(load_val);
            m_run = (load_val != 0);
            m_tc  = 1'b0;
        end else if (m_run && en) begin
            if (m_cnt == 1) begin
                m_tc = 1'b1;
`ifdef SYNC_DOWN_COUNTER_AUTORELOAD_EN
                m_cnt = m_rel;
`else
                m_cnt = 0;
                m_run = 1'b0;
`endif
            end else begin
                m_cnt = m_cnt - 1;
                m_tc  = 1'b0;
            end
        end else begin
            m_tc = 1'b0;
        end
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_cnt",  int'(cnt),  m_cnt);
            check("model_zero", int'(zero), int'(m_cnt == 0));
            check("model_tc",   int'(tc),   int'(m_tc));
            check("model_busy", int'(busy), int'(m_run));
        end
    end

    task automatic step(input logic l, input logic [W-1:0] v, input logic e);
        @(negedge clk);
        load     = l;
        load_val = v;
        en       = e;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input int c, input int t, input int b);
        check({name, "_cnt"},  int'(cnt),  c);
        check({name, "_tc"},   int'(tc),   t);
        check({name, "_busy"}, int'(busy), b);
        check({name, "_zero"}, int'(zero), int'(c == 0));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        expect_out("reset_hold", 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 1);
        expect_out("post_reset_idle", 0, 0, 0);
        chk_en = 1'b1;

        // Reset mid-count, asynchronous
        step(1, 9, 0);
        expect_out("load9", 9, 0, 1);
        repeat (3) step(0, 0, 1);
        expect_out("run3", 6, 0, 1);
        #1 rst = 1'b1;
        #1 expect_out("async_rst", 0, 0, 0);
        #1 rst = 1'b0;
        step(0, 0, 1);
        expect_out("after_rst_idle", 0, 0, 0);

`ifndef SYNC_DOWN_COUNTER_AUTORELOAD_EN
        // One-shot
        step(1, 5, 1);
        expect_out("os_load5", 5, 0, 1);
        for (int k = 4; k >= 1; k--) begin
            step(0, 0, 1);
            expect_out("os_dec", k, 0, 1);
        end
        step(0, 0, 1);
        expect_out("os_expiry", 0, 1, 0);
        step(0, 0, 1);
        expect_out("os_after", 0, 0, 0);
        step(0, 0, 1);
        expect_out("os_en_ignored", 0, 0, 0);
`else
        // Auto-reload
        step(1, 3, 1);
        expect_out("ar_load3", 3, 0, 1);
        for (int k = 0; k < 10; k++) begin
            step(0, 0, 1);
            expect_out("ar_run", (k % 3 == 0) ? 2 : (k % 3 == 1) ? 1 : 3,
                       (k % 3 == 2) ? 1 : 0, 1);
        end
        step(1, 1, 1);
        step(0, 0, 1);
        expect_out("ar_rel1_a", 1, 1, 1);
        step(0, 0, 1);
        expect_out("ar_rel1_b", 1, 1, 1);
`endif

        // Gapped enable
        step(1, 4, 0);
        expect_out("gap_load4", 4, 0, 1);
        step(0, 0, 1); expect_out("gap_e1", 3, 0, 1);
        step(0, 0, 0); expect_out("gap_e0a", 3, 0, 1);
        step(0, 0, 0); expect_out("gap_e0b", 3, 0, 1);
        step(0, 0, 1); expect_out("gap_e1b", 2, 0, 1);
        step(0, 0, 1); expect_out("gap_e1c", 1, 0, 1);
        step(0, 0, 0); expect_out("gap_e0c", 1, 0, 1);
        step(0, 0, 1);
`ifndef SYNC_DOWN_COUNTER_AUTORELOAD_EN
        expect_out("gap_expiry", 0, 1, 0);
`else
        expect_out("gap_expiry", 4, 1, 1);
`endif
        step(0, 0, 0);

        // Load priority and zero load
        step(1, 4, 0);
        step(0, 0, 1);
        step(0, 0, 1);
        expect_out("lp_at2", 2, 0, 1);
        step(1, 7, 1);
        expect_out("lp_load7", 7, 0, 1);
        step(1, 0, 1);
        expect_out("lp_load0", 0, 0, 0);
        step(0, 0, 1);
        expect_out("lp_idle", 0, 0, 0);

        // Full width: 15 down to expiry, including the 8 -> 7 carry chain
        step(1, 15, 1);
        expect_out("fw_load15", 15, 0, 1);
        for (int k = 1; k <= 14; k++) begin
            step(0, 0, 1);
            check("fw_cnt", int'(cnt), 15 - k);
            check("fw_tc", int'(tc), 0);
            if (k == 7) check("fw_1000", int'(cnt), 8);
            if (k == 8) check("fw_0111", int'(cnt), 7);
        end
        step(0, 0, 1);
`ifndef SYNC_DOWN_COUNTER_AUTORELOAD_EN
        expect_out("fw_expiry", 0, 1, 0);
`else
        expect_out("fw_expiry", 15, 1, 1);
`endif
        step(0, 0, 0);
        check("fw_tc_one_cycle", int'(tc), 0);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sync_down_counter
